ex_mem_latch: RTL and testbench

EX/MEM pipeline register plus data-memory access sequencer for the five-stage pipeline. Captures the EX-stage result each advancing cycle, drives the data-cache request for the latched load/store until `dhit`, and raises `mem_stall` to freeze upstream stages while the access is outstanding. Its registered `mem_rd`, `mem_rt`, `memRegWr` and `memWr` outputs are the MEM-stage fields the forwarding unit compares against EX sources.

---
 rtl/ex_mem_latch.sv | 159 +++++++++++++++
 tb/tb_ex_mem_latch.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_latch.sv
// rtl/ex_mem_latch.sv - EX/MEM pipeline register with data-cache access sequencer
//
// Purpose:
//   Latches the EX-stage instruction each advancing cycle, drives the data-cache
//   request for a latched load/store until dhit, and freezes upstream stages
//   with mem_stall while the access is outstanding.
//
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   ex_valid/regwr/memrd/memwr/halt, ex_rd, ex_rt, ex_aluout, ex_storedata, ex_npc
//                                 EX-stage instruction fields
//   fwd_store, wb_wdata           store-operand forwarding from write-back
//   flush, hold                   bubble insertion / external freeze
//   dhit, dmemload                cache completion and load data
//   dmemREN, dmemWEN, dmemaddr, dmemstore  cache request
//   mem_valid, memRegWr, memWr, mem_rd, mem_rt, mem_aluout, mem_rdata, mem_npc
//                                 MEM-stage fields toward MEM/WB and forwarding
//   mem_stall, halt, stall_cnt    freeze request, sticky halt, stall-cycle counter
`timescale 1ns/1ps

module ex_mem_latch #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ex_valid,
  input  logic             ex_regwr,
  input  logic             ex_memrd,
  input  logic             ex_memwr,
  input  logic             ex_halt,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       ex_rt,
  input  logic [31:0]      ex_aluout,
  input  logic [31:0]      ex_storedata,
  input  logic [31:0]      ex_npc,
  input  logic             fwd_store,
  input  logic [31:0]      wb_wdata,
  input  logic             flush,
  input  logic             hold,
  input  logic             dhit,
  input  logic [31:0]      dmemload,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic [31:0]      dmemaddr,
  output logic [31:0]      dmemstore,
  output logic             mem_valid,
  output logic             memRegWr,
  output logic             memWr,
  output logic [4:0]       mem_rd,
  output logic [4:0]       mem_rt,
  output logic [31:0]      mem_aluout,
  output logic [31:0]      mem_rdata,
  output logic [31:0]      mem_npc,
  output logic             mem_stall,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state;
  state_t      capState;
  logic        memRegWrQ;
  logic        memRdQ;
  logic        memWrQ;
  logic        memHaltQ;
  logic [31:0] storeQ;
  logic [31:0] loadQ;
  logic        adv;
  logic        bubble;
  logic        capMem;
  logic        inAccess;

  assign inAccess  = (state == ACCESS);
  assign mem_stall = inAccess && !dhit;
  assign adv       = !mem_stall && !hold;
  // Once halted, nothing further may enter the MEM stage.
  assign bubble    = flush || halt;
  assign capMem    = !bubble && ex_valid && (ex_memrd || ex_memwr);
  assign capState  = capMem ? ACCESS : IDLE;

  assign memRegWr  = mem_valid && memRegWrQ;
  assign memWr     = mem_valid && memWrQ;
  // Read wins if both controls were ever latched, so the cache never sees both.
  assign dmemREN   = inAccess && memRdQ;
  assign dmemWEN   = inAccess && memWrQ && !memRdQ;
  assign dmemaddr  = mem_aluout;
  assign dmemstore = storeQ;
  // Bypass the load register in the hit cycle so WB sees data without a bubble.
  assign mem_rdata = (inAccess && dhit) ? dmemload : loadQ;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      mem_valid  <= 1'b0;
      memRegWrQ  <= 1'b0;
      memRdQ     <= 1'b0;
      memWrQ     <= 1'b0;
      memHaltQ   <= 1'b0;
      mem_rd     <= 5'd0;
      mem_rt     <= 5'd0;
      mem_aluout <= 32'd0;
      storeQ     <= 32'd0;
      mem_npc    <= 32'd0;
      loadQ      <= 32'd0;
      halt       <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      if (adv) begin
        if (bubble) begin
          // Data fields are left as they were; only controls are cleared.
          mem_valid <= 1'b0;
          memRegWrQ <= 1'b0;
          memRdQ    <= 1'b0;
          memWrQ    <= 1'b0;
          memHaltQ  <= 1'b0;
        end else begin
          mem_valid  <= ex_valid;
          memRegWrQ  <= ex_regwr;
          memRdQ     <= ex_memrd;
          memWrQ     <= ex_memwr;
          memHaltQ   <= ex_halt;
          mem_rd     <= ex_rd;
          mem_rt     <= ex_rt;
          mem_aluout <= ex_aluout;
          storeQ     <= fwd_store ? wb_wdata : ex_storedata;
          mem_npc    <= ex_npc;
        end
      end

      case (state)
        ACCESS: begin
          if (dhit) begin
            // A hit under hold parks in DONE so the request is not repeated.
            state <= adv ? capState : DONE;
          end
        end
        default: begin
          if (adv) begin
            state <= capState;
          end
        end
      endcase

      if (inAccess && dhit) begin
        loadQ <= dmemload;
      end

      if (mem_valid && memHaltQ) begin
        halt <= 1'b1;
      end

      if (mem_stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_latch.sv
// tb/tb_ex_mem_latch.sv - self-checking bench for ex_mem_latch
`timescale 1ns/1ps

module tb_ex_mem_latch;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ex_valid, ex_regwr, ex_memrd, ex_memwr, ex_halt;
  logic [4:0]  ex_rd, ex_rt;
  logic [31:0] ex_aluout, ex_storedata, ex_npc;
  logic        fwd_store;
  logic [31:0] wb_wdata;
  logic        flush, hold, dhit;
  logic [31:0] dmemload;
  logic        dmemREN, dmemWEN;
  logic [31:0] dmemaddr, dmemstore;
  logic        mem_valid, memRegWr, memWr;
  logic [4:0]  mem_rd, mem_rt;
  logic [31:0] mem_aluout, mem_rdata, mem_npc;
  logic        mem_stall, halt;
  logic [15:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  ex_mem_latch #(.CNT_W(16)) dut (
    .CLK(CLK), .RST(RST),
    .ex_valid(ex_valid), .ex_regwr(ex_regwr), .ex_memrd(ex_memrd), .ex_memwr(ex_memwr),
    .ex_halt(ex_halt), .ex_rd(ex_rd), .ex_rt(ex_rt), .ex_aluout(ex_aluout),
    .ex_storedata(ex_storedata), .ex_npc(ex_npc), .fwd_store(fwd_store), .wb_wdata(wb_wdata),
    .flush(flush), .hold(hold), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_valid(mem_valid), .memRegWr(memRegWr), .memWr(memWr), .mem_rd(mem_rd), .mem_rt(mem_rt),
    .mem_aluout(mem_aluout), .mem_rdata(mem_rdata), .mem_npc(mem_npc),
    .mem_stall(mem_stall), .halt(halt), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        valid, regwr, memrd, memwr, hlt;
    logic [4:0]  rd, rt;
    logic [31:0] alu, st, npc;
  } instr_t;

  // Reference model: the instruction currently held in the MEM stage,
  // the sticky halt, the stall tally and the last completed load value.
  instr_t      cur;
  instr_t      m;
  logic        haltM;
  logic [15:0] stallM;
  logic [31:0] loadM;

  function automatic instr_t rand_instr();
    instr_t r;
    int kind;
    kind    = $urandom_range(0, 3);
    r.valid = (kind != 3);
    r.regwr = (kind <= 1) ? 1'b1 : 1'($urandom_range(0, 1));
    r.memrd = (kind == 1) || (kind == 3 && $urandom_range(0, 1) == 1);
    r.memwr = (kind == 2);
    r.hlt   = 1'b0;
    r.rd    = 5'($urandom);
    r.rt    = 5'($urandom);
    r.alu   = $urandom & 32'hFFFF_FFFC;
    r.st    = $urandom;
    r.npc   = $urandom;
    return r;
  endfunction

  task automatic apply(input instr_t x);
    cur          = x;
    ex_valid     = x.valid;
    ex_regwr     = x.regwr;
    ex_memrd     = x.memrd;
    ex_memwr     = x.memwr;
    ex_halt      = x.hlt;
    ex_rd        = x.rd;
    ex_rt        = x.rt;
    ex_aluout    = x.alu;
    ex_storedata = x.st;
    ex_npc       = x.npc;
  endtask

  // Advance one clock. cap: this edge is an advancing edge; st: stall is high this cycle.
  task automatic step(input bit cap, input bit st);
    bit bub;
    bub = flush || haltM;
    if (m.valid && m.hlt) haltM = 1'b1;
    if (st && stallM != 16'hFFFF) stallM = stallM + 16'd1;
    if (cap) begin
      if (bub) begin
        m.valid = 0; m.regwr = 0; m.memrd = 0; m.memwr = 0; m.hlt = 0;
      end else begin
        m    = cur;
        m.st = fwd_store ? wb_wdata : cur.st;
      end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    instr_t z;
    z = '0;
    apply(z);
    fwd_store = 0; wb_wdata = 0; flush = 0; hold = 0; dhit = 0; dmemload = 0;
    RST = 1;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    RST = 0;
    m = '0; haltM = 0; stallM = 0; loadM = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({mem_valid, memRegWr, memWr, mem_rd, mem_rt, mem_aluout, mem_rdata, mem_npc,
         dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, halt, stall_cnt} !== '0) begin
      fails++;
      $display("FAIL reset: outputs not all zero (valid=%b rd=%0d alu=%h rdata=%h stall=%b halt=%b cnt=%0d) expected 0",
               mem_valid, mem_rd, mem_aluout, mem_rdata, mem_stall, halt, stall_cnt);
    end
  endtask

  task automatic test_alu();
    instr_t x;
    do_reset();
    x = '0; x.valid = 1; x.regwr = 1; x.rd = 5; x.alu = 32'h10;
    apply(x);
    step(1, 0);
    tests++;
    if ({mem_rd, memRegWr, mem_aluout, mem_valid} !== {5'd5, 1'b1, 32'h10, 1'b1}) begin
      fails++;
      $display("FAIL alu_capture: rd=%0d regwr=%b alu=%h valid=%b expected rd=5 regwr=1 alu=10 valid=1",
               mem_rd, memRegWr, mem_aluout, mem_valid);
    end
    tests++;
    if ({dmemREN, dmemWEN, mem_stall} !== 3'b000) begin
      fails++;
      $display("FAIL alu_noreq: ren=%b wen=%b stall=%b expected 000", dmemREN, dmemWEN, mem_stall);
    end
  endtask

  task automatic test_load_miss();
    instr_t x;
    int renCycles;
    do_reset();
    x = '0; x.valid = 1; x.regwr = 1; x.memrd = 1; x.rd = 3; x.alu = 32'h40;
    apply(x);
    step(1, 0);
    x = '0; apply(x);
    renCycles = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      renCycles += int'(dmemREN);
      tests++;
      if ({mem_stall, dmemaddr} !== {1'b1, 32'h40}) begin
        fails++;
        $display("FAIL load_miss_stall: stall=%b addr=%h expected 1 / 40", mem_stall, dmemaddr);
      end
      step(0, 1);
    end
    dhit = 1; dmemload = 32'hDEADBEEF;
    #1;
    renCycles += int'(dmemREN);
    tests++;
    if ({mem_stall, mem_rdata} !== {1'b0, 32'hDEADBEEF}) begin
      fails++;
      $display("FAIL load_hit: stall=%b rdata=%h expected 0 / deadbeef", mem_stall, mem_rdata);
    end
    step(1, 0);
    dhit = 0;
    #1;
    tests++;
    if ({renCycles, dmemREN, mem_rdata, stall_cnt} !== {32'd4, 1'b0, 32'hDEADBEEF, 16'd3}) begin
      fails++;
      $display("FAIL load_summary: ren_cycles=%0d ren=%b rdata=%h cnt=%0d expected 4 0 deadbeef 3",
               renCycles, dmemREN, mem_rdata, stall_cnt);
    end
  endtask

  task automatic test_store_fwd();
    instr_t x;
    do_reset();
    x = '0; x.valid = 1; x.memwr = 1; x.rt = 8; x.alu = 32'h100; x.st = 32'hAAAA;
    apply(x);
    fwd_store = 1; wb_wdata = 32'h1234;
    step(1, 0);
    fwd_store = 0;
    tests++;
    if ({dmemWEN, dmemREN, dmemstore, memWr, mem_stall} !== {1'b1, 1'b0, 32'h1234, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL store_fwd: wen=%b ren=%b store=%h memwr=%b stall=%b expected 1 0 1234 1 1",
               dmemWEN, dmemREN, dmemstore, memWr, mem_stall);
    end
    x = '0; apply(x);
    dhit = 1;
    step(1, 0);
    dhit = 0;
    #1;
    tests++;
    if ({dmemWEN, mem_stall} !== 2'b00) begin
      fails++;
      $display("FAIL store_done: wen=%b stall=%b expected 00", dmemWEN, mem_stall);
    end
  endtask

  task automatic test_hold_hit();
    instr_t x;
    do_reset();
    x = '0; x.valid = 1; x.regwr = 1; x.memrd = 1; x.rd = 2; x.alu = 32'h80;
    apply(x);
    step(1, 0);
    x = '0; x.valid = 1; x.regwr = 1; x.rd = 9; x.alu = 32'h55;
    apply(x);
    hold = 1; dhit = 1; dmemload = 32'hCAFEF00D;
    #1;
    tests++;
    if ({mem_stall, mem_rdata} !== {1'b0, 32'hCAFEF00D}) begin
      fails++;
      $display("FAIL hold_hit: stall=%b rdata=%h expected 0 / cafef00d", mem_stall, mem_rdata);
    end
    step(0, 0);
    dhit = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      tests++;
      if ({dmemREN, dmemWEN, mem_stall, mem_valid, mem_rd, mem_rdata} !==
          {3'b000, 1'b1, 5'd2, 32'hCAFEF00D}) begin
        fails++;
        $display("FAIL hold_done: ren=%b wen=%b stall=%b valid=%b rd=%0d rdata=%h expected 0 0 0 1 2 cafef00d",
                 dmemREN, dmemWEN, mem_stall, mem_valid, mem_rd, mem_rdata);
      end
      step(0, 0);
    end
    hold = 0;
    step(1, 0);
    tests++;
    if ({mem_rd, mem_aluout, dmemREN} !== {5'd9, 32'h55, 1'b0}) begin
      fails++;
      $display("FAIL hold_release: rd=%0d alu=%h ren=%b expected 9 55 0", mem_rd, mem_aluout, dmemREN);
    end
  endtask

  task automatic test_flush();
    instr_t x;
    do_reset();
    x = '0; x.valid = 1; x.regwr = 1; x.memwr = 1; x.rd = 6; x.alu = 32'h20;
    apply(x);
    flush = 1;
    step(1, 0);
    flush = 0;
    tests++;
    if ({mem_valid, memRegWr, memWr, dmemWEN, mem_stall} !== 5'b00000) begin
      fails++;
      $display("FAIL flush_bubble: valid=%b regwr=%b memwr=%b wen=%b stall=%b expected 00000",
               mem_valid, memRegWr, memWr, dmemWEN, mem_stall);
    end
    x = '0; x.valid = 1; x.regwr = 1; x.memrd = 1; x.rd = 11; x.alu = 32'h44;
    apply(x);
    step(1, 0);
    x = '0; x.valid = 1; x.regwr = 1; x.rd = 12; apply(x);
    flush = 1;
    step(0, 1);
    tests++;
    if ({mem_valid, memRegWr, mem_rd, dmemREN, mem_stall} !== {1'b1, 1'b1, 5'd11, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL flush_in_stall: valid=%b regwr=%b rd=%0d ren=%b stall=%b expected 1 1 11 1 1",
               mem_valid, memRegWr, mem_rd, dmemREN, mem_stall);
    end
    x = '0; apply(x);
    flush = 0; dhit = 1;
    step(1, 0);
    dhit = 0;
  endtask

  task automatic test_halt();
    instr_t x;
    do_reset();
    x = '0; x.valid = 1; x.regwr = 1; x.hlt = 1; x.rd = 7;
    apply(x);
    step(1, 0);
    tests++;
    if ({mem_valid, halt} !== 2'b10) begin
      fails++;
      $display("FAIL halt_capture: valid=%b halt=%b expected 1 0", mem_valid, halt);
    end
    x = '0; apply(x);
    step(1, 0);
    tests++;
    if (halt !== 1'b1) begin
      fails++;
      $display("FAIL halt_set: halt=%b expected 1", halt);
    end
    for (int k = 0; k < 3; k++) begin
      x = rand_instr(); x.valid = 1; x.memrd = 0; x.memwr = 0;
      apply(x);
      step(1, 0);
      tests++;
      if ({halt, mem_valid, memRegWr, memWr, dmemREN} !== 5'b10000) begin
        fails++;
        $display("FAIL halt_bubble: halt=%b valid=%b regwr=%b memwr=%b ren=%b expected 1 0 0 0 0",
                 halt, mem_valid, memRegWr, memWr, dmemREN);
      end
    end
    do_reset();
    tests++;
    if (halt !== 1'b0) begin
      fails++;
      $display("FAIL halt_reset: halt=%b expected 0", halt);
    end
  endtask

  task automatic test_random();
    instr_t x;
    bit pending, isMem;
    int n;
    do_reset();
    pending = 0;
    for (int i = 0; i < 80; i++) begin
      x = rand_instr(); apply(x);
      flush = ($urandom_range(0, 5) == 0);
      fwd_store = 1'($urandom_range(0, 1)); wb_wdata = $urandom;
      hold = 0; dhit = 0;
      if (pending) begin
        dhit = 1; dmemload = $urandom;
        #1;
        tests++;
        if ({mem_stall, mem_rdata} !== {1'b0, dmemload}) begin
          fails++;
          $display("FAIL rnd_hit: stall=%b rdata=%h expected 0 / %h", mem_stall, mem_rdata, dmemload);
        end
        loadM = dmemload;
      end
      step(1, 0);
      dhit = 0;
      pending = 0;
      isMem = m.valid && (m.memrd || m.memwr);
      #1;
      tests++;
      if ({mem_valid, memRegWr, memWr} !== {m.valid, m.valid & m.regwr, m.valid & m.memwr}) begin
        fails++;
        $display("FAIL rnd_ctrl: valid/regwr/memwr=%b%b%b expected %b%b%b", mem_valid, memRegWr, memWr,
                 m.valid, m.valid & m.regwr, m.valid & m.memwr);
      end
      if (m.valid) begin
        tests++;
        if ({mem_rd, mem_rt, mem_aluout, mem_npc} !== {m.rd, m.rt, m.alu, m.npc}) begin
          fails++;
          $display("FAIL rnd_fields: rd=%0d rt=%0d alu=%h npc=%h expected %0d %0d %h %h",
                   mem_rd, mem_rt, mem_aluout, mem_npc, m.rd, m.rt, m.alu, m.npc);
        end
      end
      tests++;
      if ({dmemREN, dmemWEN, mem_stall, mem_rdata} !== {isMem && m.memrd, isMem && m.memwr, isMem, loadM}) begin
        fails++;
        $display("FAIL rnd_req: ren=%b wen=%b stall=%b rdata=%h expected %b %b %b %h", dmemREN, dmemWEN,
                 mem_stall, mem_rdata, isMem && m.memrd, isMem && m.memwr, isMem, loadM);
      end
      if (isMem) begin
        n = $urandom_range(0, 3);
        for (int k = 0; k < n; k++) begin
          x = rand_instr(); apply(x);
          flush = 1'($urandom_range(0, 1));
          #1;
          tests++;
          if ({dmemREN, dmemWEN, mem_stall, dmemaddr} !== {m.memrd, m.memwr, 1'b1, m.alu} ||
              (m.memwr && dmemstore !== m.st)) begin
            fails++;
            $display("FAIL rnd_miss: ren=%b wen=%b stall=%b addr=%h store=%h expected %b %b 1 %h %h",
                     dmemREN, dmemWEN, mem_stall, dmemaddr, dmemstore, m.memrd, m.memwr, m.alu, m.st);
          end
          step(0, 1);
        end
        if ($urandom_range(0, 2) == 0) begin
          hold = 1; dhit = 1; dmemload = $urandom;
          #1;
          tests++;
          if ({mem_stall, mem_rdata} !== {1'b0, dmemload}) begin
            fails++;
            $display("FAIL rnd_hold_hit: stall=%b rdata=%h expected 0 / %h", mem_stall, mem_rdata, dmemload);
          end
          loadM = dmemload;
          step(0, 0);
          for (int k = 0; k < 2; k++) begin
            dhit = 1'($urandom_range(0, 1)); dmemload = $urandom;
            #1;
            tests++;
            if ({dmemREN, dmemWEN, mem_stall, mem_rdata} !== {3'b000, loadM}) begin
              fails++;
              $display("FAIL rnd_done: ren=%b wen=%b stall=%b rdata=%h expected 0 0 0 %h",
                       dmemREN, dmemWEN, mem_stall, mem_rdata, loadM);
            end
            step(0, 0);
          end
          hold = 0; dhit = 0;
        end else begin
          pending = 1;
        end
      end
    end
    if (pending) begin
      x = '0; apply(x);
      flush = 0; dhit = 1;
      step(1, 0);
      dhit = 0;
    end
    #1;
    tests++;
    if ({stall_cnt, halt, mem_stall} !== {stallM, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL rnd_stall_cnt: cnt=%0d halt=%b stall=%b expected %0d 0 0", stall_cnt, halt, mem_stall, stallM);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_miss();
    test_store_fwd();
    test_hold_hit();
    test_flush();
    test_halt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
